// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM states, default
// widths and the layout of the queued request record.
package mem_access_ctrl_pkg;

    localparam int DEF_ADDR_W  = 7;
    localparam int DEF_DATA_W  = 32;
    localparam int REQ_WRITE_W = 1;
    localparam int PHASE_W     = 3;   // strobe phase counter, counts 1..7

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_PULSE   = 3'd1,
        RD_PULSE   = 3'd2,
        RD_CAPTURE = 3'd3,
        GAP        = 3'd4
    } state_e;

    // Record layout, MSB first: {write, addr, wdata}
    function automatic int req_rec_w(input int addr_w, input int data_w);
        return REQ_WRITE_W + addr_w + data_w;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Two-entry request FIFO. Full blocks pushes even when a pop happens in the
// same cycle, so the write side never sees a pass-through path.
module mem_req_fifo
    import mem_access_ctrl_pkg::*;
#(
    parameter int REC_W = req_rec_w(DEF_ADDR_W, DEF_DATA_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [REC_W-1:0] push_data_i,
    input  logic             pop_i,
    output logic [REC_W-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [REC_W-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == 2'd2);
    assign empty_o    = (count_q == 2'd0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // NOTE: state is updated with <= so every flop samples pre-edge values,
    // independent of statement order or of other always_ff blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // NOTE: storage is deliberately not reset; count_q guards every read, so
    // clearing the payload would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: queues load/store requests and replays them to a
// strobe-driven memory, returning load data as a one-cycle response pulse.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    output logic              trigWrite,
    output logic              trigRead,
    input  logic [DATA_W-1:0] readData,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy
);

    localparam int                 REC_W   = req_rec_w(ADDR_W, DATA_W);
    localparam logic [PHASE_W-1:0] WR_LAST = PHASE_W'(WR_CYCLES);
    localparam logic [PHASE_W-1:0] RD_LAST = PHASE_W'(RD_CYCLES);

    state_e              state_q;
    logic [PHASE_W-1:0]  phase_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                trig_wr_q;
    logic                trig_rd_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                ready_en_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [REC_W-1:0]    head_rec;
    logic                head_write;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_wdata;

    // ready_en_q holds req_ready low through reset and releases it on the
    // first edge afterwards, keeping rst_n off the ready output path.
    assign req_ready = ready_en_q && !fifo_full;
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == IDLE) && !fifo_empty;

    assign head_write = head_rec[REC_W-1];
    assign head_addr  = head_rec[DATA_W +: ADDR_W];
    assign head_wdata = head_rec[DATA_W-1:0];

    mem_req_fifo #(
        .REC_W (REC_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({req_write, req_addr, req_wdata}),
        .pop_i       (pop),
        .pop_data_o  (head_rec),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            trig_wr_q    <= 1'b0;
            trig_rd_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        addr_q  <= head_addr;
                        phase_q <= PHASE_W'(1);
                        if (head_write) begin
                            wdata_q   <= head_wdata;
                            trig_wr_q <= 1'b1;
                            state_q   <= WR_PULSE;
                        end else begin
                            trig_rd_q <= 1'b1;
                            state_q   <= RD_PULSE;
                        end
                    end
                end
                WR_PULSE: begin
                    if (phase_q == WR_LAST) begin
                        trig_wr_q <= 1'b0;
                        state_q   <= GAP;
                    end else begin
                        phase_q <= phase_q + PHASE_W'(1);
                    end
                end
                RD_PULSE: begin
                    if (phase_q == RD_LAST) begin
                        trig_rd_q <= 1'b0;
                        state_q   <= RD_CAPTURE;
                    end else begin
                        phase_q <= phase_q + PHASE_W'(1);
                    end
                end
                RD_CAPTURE: begin
                    // Memory data has had a full strobe-free cycle to settle.
                    resp_rdata_q <= readData;
                    resp_valid_q <= 1'b1;
                    state_q      <= GAP;
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign address    = addr_q;
    assign writeData  = wdata_q;
    assign trigWrite  = trig_wr_q;
    assign trigRead   = trig_rd_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed requests feed expectation
// queues that a negedge monitor drains as strobes and responses appear.
module tb_mem_access_ctrl;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [6:0]  address;
    logic [31:0] writeData;
    logic        trigWrite;
    logic        trigRead;
    logic [31:0] readData;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;

    logic        v2 = 1'b0;
    logic        w2 = 1'b0;
    logic [6:0]  a2 = '0;
    logic [31:0] d2 = '0;
    logic        rdy2;
    logic [6:0]  addr2;
    logic [31:0] wd2;
    logic        tw2;
    logic        tr2;
    logic [31:0] rdin2;
    logic        rv2;
    logic [31:0] rr2;
    logic        busy2;

    logic [31:0] mem_model [128];
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;

    wr_exp_t     exp_wr_q[$];
    logic [6:0]  exp_rd_addr_q[$];
    logic [31:0] exp_rd_q[$];

    always #5 clk = ~clk;

    assign readData = mem_model[address];
    assign rdin2    = 32'hC0DE_0000 | {25'd0, addr2};

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .address(address), .writeData(writeData), .trigWrite(trigWrite),
        .trigRead(trigRead), .readData(readData), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .busy(busy)
    );

    mem_access_ctrl #(.WR_CYCLES(7), .RD_CYCLES(3)) dut_slow (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2),
        .req_write(w2), .req_addr(a2), .req_wdata(d2),
        .address(addr2), .writeData(wd2), .trigWrite(tw2),
        .trigRead(tr2), .readData(rdin2), .resp_valid(rv2),
        .resp_rdata(rr2), .busy(busy2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called away from clock edges; returns #1 after the accepting edge.
    task automatic send(input logic w, input logic [6:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
        int waited = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            check("send_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (w) begin
            exp_wr_q.push_back('{addr: a, data: d});
        end else begin
            exp_rd_addr_q.push_back(a);
            exp_rd_q.push_back(exp_rd);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk); #1;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Memory model: stores land while the write strobe is high.
    initial begin
        forever begin
            @(negedge clk);
            if (trigWrite) mem_model[address] = writeData;
        end
    end

    // Monitor: strobe ordering, widths, address hold and load responses.
    initial begin
        logic       prev_tw = 1'b0;
        logic       prev_tr = 1'b0;
        int         wr_len = 0;
        int         rd_len = 0;
        int         low_run = 0;
        bit         seen_strobe = 1'b0;
        logic [6:0]  cap_addr = '0;
        logic [31:0] cap_wd = '0;
        wr_exp_t    e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_tw = 1'b0; prev_tr = 1'b0; wr_len = 0; rd_len = 0;
                low_run = 0; seen_strobe = 1'b0;
            end else begin
                if (req_valid && req_ready) hs_count++;
                if (trigWrite && trigRead) check("strobe_overlap", 1, 0);
                if ((trigWrite && !prev_tw) || (trigRead && !prev_tr)) begin
                    if (seen_strobe) check("strobe_gap_ge2", low_run >= 2, 1);
                    seen_strobe = 1'b1;
                end
                if (trigWrite && !prev_tw) begin
                    if (exp_wr_q.size() == 0) check("unexpected_write", 1, 0);
                    else begin
                        e = exp_wr_q.pop_front();
                        check("wr_address", address, e.addr);
                        check("wr_data", writeData, e.data);
                    end
                    cap_addr = address; cap_wd = writeData;
                end
                if (trigRead && !prev_tr) begin
                    if (exp_rd_addr_q.size() == 0) check("unexpected_read", 1, 0);
                    else check("rd_address", address, exp_rd_addr_q.pop_front());
                    cap_addr = address;
                end
                if (!trigWrite && prev_tw) begin
                    check("wr_width", wr_len, 2);
                    check("wr_hold_addr_gap", address, cap_addr);
                    check("wr_hold_data_gap", writeData, cap_wd);
                end
                if (!trigRead && prev_tr) begin
                    check("rd_width", rd_len, 1);
                    check("rd_hold_addr", address, cap_addr);
                end
                if (resp_valid) begin
                    if (exp_rd_q.size() == 0) check("unexpected_resp", 1, 0);
                    else check("resp_rdata", resp_rdata, exp_rd_q.pop_front());
                end
                wr_len  = trigWrite ? (prev_tw ? wr_len + 1 : 1) : 0;
                rd_len  = trigRead  ? (prev_tr ? rd_len + 1 : 1) : 0;
                low_run = (trigWrite || trigRead) ? 0 : low_run + 1;
                prev_tw = trigWrite;
                prev_tr = trigRead;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0;
        int wcnt;
        int rcnt;
        int resp_at;
        int nresp;
        logic [31:0] rdat;

        for (int i = 0; i < 128; i++) mem_model[i] = 32'h0;
        mem_model[2] = 32'hBBBB_CCCC;
        mem_model[3] = 32'hBCBC_BCBC;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_trigWrite", trigWrite, 0);
        check("rst_trigRead", trigRead, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_address", address, 0);
        check("rst_writeData", writeData, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        check("ready_after_reset", req_ready, 1);

        // Single store: strobe in cycles N+1..N+2, GAP at N+3
        send(1'b1, 7'd0, 32'hABCD_ABCD, 32'h0);
        check("st_N_trigWrite", trigWrite, 0);
        check("st_N_busy", busy, 1);
        step();
        check("st_N1_trigWrite", trigWrite, 1);
        check("st_N1_address", address, 0);
        check("st_N1_writeData", writeData, 32'hABCD_ABCD);
        step();
        check("st_N2_trigWrite", trigWrite, 1);
        step();
        check("st_N3_trigWrite", trigWrite, 0);
        check("st_N3_writeData", writeData, 32'hABCD_ABCD);
        wait_idle();
        check("mem0", mem_model[0], 32'hABCD_ABCD);

        // Single load: strobe at N+1, response at N+3
        send(1'b0, 7'd2, 32'hFFFF_FFFF, 32'hBBBB_CCCC);
        step();
        check("ld_N1_trigRead", trigRead, 1);
        check("ld_N1_address", address, 2);
        check("ld_N1_writeData_held", writeData, 32'hABCD_ABCD);
        step();
        check("ld_N2_trigRead", trigRead, 0);
        check("ld_N2_resp_valid", resp_valid, 0);
        step();
        check("ld_N3_resp_valid", resp_valid, 1);
        check("ld_N3_resp_rdata", resp_rdata, 32'hBBBB_CCCC);
        step();
        check("ld_N4_resp_valid", resp_valid, 0);
        check("ld_N4_rdata_held", resp_rdata, 32'hBBBB_CCCC);
        wait_idle();

        // Back-to-back: two requests queued behind the active one fill the FIFO
        send(1'b1, 7'd1, 32'hAAAA_AAAA, 32'h0);
        send(1'b0, 7'd1, 32'h0, 32'hAAAA_AAAA);
        send(1'b0, 7'd3, 32'h0, 32'hBCBC_BCBC);
        check("b2b_ready_full", req_ready, 0);
        wait_idle();
        check("b2b_mem1", mem_model[1], 32'hAAAA_AAAA);
        check("b2b_rd_drained", exp_rd_q.size(), 0);

        // Valid held through a full FIFO: exactly four handshakes
        hs0 = hs_count;
        send(1'b1, 7'd5, 32'h1111_1111, 32'h0);
        send(1'b1, 7'd6, 32'h2222_2222, 32'h0);
        send(1'b0, 7'd5, 32'h0, 32'h1111_1111);
        send(1'b0, 7'd6, 32'h0, 32'h2222_2222);
        wait_idle();
        check("hold_handshakes", hs_count - hs0, 4);
        check("hold_mem5", mem_model[5], 32'h1111_1111);
        check("hold_mem6", mem_model[6], 32'h2222_2222);
        check("hold_wr_drained", exp_wr_q.size(), 0);
        check("hold_rd_drained", exp_rd_q.size(), 0);

        // Reset in the middle of a read strobe
        send(1'b0, 7'd2, 32'h0, 32'hBBBB_CCCC);
        step();
        check("abort_trigRead_before", trigRead, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_trigRead", trigRead, 0);
        check("abort_busy", busy, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_resp_rdata", resp_rdata, 0);
        check("abort_req_ready", req_ready, 0);
        exp_wr_q.delete();
        exp_rd_addr_q.delete();
        exp_rd_q.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        check("abort_ready_after", req_ready, 1);
        check("abort_no_resp", resp_valid, 0);
        send(1'b0, 7'd3, 32'h0, 32'hBCBC_BCBC);
        step();
        check("post_ld_N1_trigRead", trigRead, 1);
        step();
        check("post_ld_N2_trigRead", trigRead, 0);
        step();
        check("post_ld_N3_resp_valid", resp_valid, 1);
        check("post_ld_N3_rdata", resp_rdata, 32'hBCBC_BCBC);
        wait_idle();
        send(1'b1, 7'd7, 32'h7070_7070, 32'h0);
        step();
        check("post_st_N1_trigWrite", trigWrite, 1);
        step();
        check("post_st_N2_trigWrite", trigWrite, 1);
        step();
        check("post_st_N3_trigWrite", trigWrite, 0);
        wait_idle();
        check("post_mem7", mem_model[7], 32'h7070_7070);

        // Wide strobes: WR_CYCLES=7, RD_CYCLES=3
        check("slow_ready", rdy2, 1);
        v2 = 1'b1; w2 = 1'b1; a2 = 7'd9; d2 = 32'h7777_0009;
        step();
        v2 = 1'b0;
        wcnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (tw2) wcnt++;
            if (tr2) check("slow_wr_no_read", tr2, 0);
        end
        check("slow_wr_width", wcnt, 7);
        check("slow_wr_addr", addr2, 9);
        check("slow_wr_data", wd2, 32'h7777_0009);
        v2 = 1'b1; w2 = 1'b0; a2 = 7'd4; d2 = 32'h0;
        step();
        v2 = 1'b0;
        rcnt = 0; resp_at = -1; nresp = 0; rdat = '0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (tr2) rcnt++;
            if (rv2) begin
                resp_at = i; nresp++; rdat = rr2;
            end
        end
        check("slow_rd_width", rcnt, 3);
        check("slow_resp_count", nresp, 1);
        check("slow_resp_latency", resp_at, 5);
        check("slow_resp_rdata", rdat, 32'hC0DE_0004);
        check("slow_busy_end", busy2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7, memory word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter WR_CYCLES, default 2, trigWrite high-time in clocks; legal range 1..7.
REQ-004 Parameter RD_CYCLES, default 1, trigRead high-time in clocks; legal range 1..7.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request queue can accept a request.
REQ-009 req_write  input  1  1 = store, 0 = load.
REQ-010 req_addr  input  ADDR_W  word address.
REQ-011 req_wdata  input  DATA_W  store data, ignored for loads.
REQ-012 address  output  ADDR_W  memory address.
REQ-013 writeData  output  DATA_W  memory write data.
REQ-014 trigWrite  output  1  memory write strobe.
REQ-015 trigRead  output  1  memory read strobe.
REQ-016 readData  input  DATA_W  memory read data.
REQ-017 resp_valid  output  1  one-cycle load-completion pulse.
REQ-018 resp_rdata  output  DATA_W  load data, valid while resp_valid = 1.
REQ-019 busy  output  1  FSM not in IDLE, or queue non-empty.

Function
REQ-020 Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1; it is then written into a 2-entry FIFO holding {write, addr, wdata}.
REQ-021 req_ready = FIFO not full; a pop in the same cycle does not make a full FIFO ready (no pass-through).
REQ-022 FSM states: IDLE, WR_PULSE, RD_PULSE, RD_CAPTURE, GAP.
REQ-023 IDLE with FIFO non-empty: on the next edge, pop the head, load address/writeData, start the phase counter at 1, and go to WR_PULSE or RD_PULSE.
REQ-024 IDLE with FIFO empty: stay in IDLE.
REQ-025 WR_PULSE: trigWrite = 1 for exactly WR_CYCLES clocks, then go to GAP.
REQ-026 RD_PULSE: trigRead = 1 for exactly RD_CYCLES clocks, then go to RD_CAPTURE.
REQ-027 RD_CAPTURE: one clock with trigRead = 0; at its end, register readData into resp_rdata and assert resp_valid for exactly the following cycle; then go to GAP.
REQ-028 GAP: one clock with both strobes low, then go to IDLE; every strobe is therefore separated from the next by at least 2 low clocks.
REQ-029 trigWrite and trigRead are registered outputs and are never high in the same cycle.
REQ-030 address and writeData stay constant from the pop until the FSM leaves GAP.
REQ-031 writeData is loaded only for stores; it holds its previous value during loads.
REQ-032 Latency for a store accepted at edge N into an empty, idle block: pop at edge N+1; trigWrite high for cycles N+1 .. N+WR_CYCLES.
REQ-033 Latency for a load under the same conditions: trigRead high for RD_CYCLES cycles from N+1; resp_valid high in cycle N+RD_CYCLES+2.
REQ-034 Requests complete in acceptance order; there is no response backpressure.
REQ-035 resp_rdata holds its value until the next load capture.

Reset
REQ-036 While rst_n = 0, asynchronously:
- FSM = IDLE; FIFO empty.
- trigWrite = 0, trigRead = 0, resp_valid = 0.
- address = 0, writeData = 0, resp_rdata = 0.
- req_ready = 0.
REQ-037 Reset during an operation aborts it: any strobe drops immediately and the aborted load produces no response.
REQ-038 req_ready rises in the first cycle after rst_n deasserts.

Structure
REQ-039 The shared package holds the state enumeration, the default ADDR_W/DATA_W, and the request-record field widths.
REQ-040 The 2-entry FIFO is one sub-module, mem_req_fifo (push/pop/full/empty), parameterised by record width.

Verification
REQ-041 Store addr 0, data 0xABCDABCD -> trigWrite high 2 cycles, address 0, writeData 0xABCDABCD stable through GAP; memoryFile[0] = 0xABCDABCD.
REQ-042 Preload memoryFile[2] = 0xBBBBCCCC; load addr 2 -> trigRead high 1 cycle; resp_valid one pulse 3 cycles after acceptance; resp_rdata = 0xBBBBCCCC.
REQ-043 Back-to-back requests (store 1/0xAAAAAAAA, load 1, load 3 with memoryFile[3] = 0xBCBCBCBC):
- req_ready falls after 2 requests are queued.
- Strobes never overlap and have ≥2 low cycles between them.
- Responses arrive in order: 0xAAAAAAAA then 0xBCBCBCBC.
REQ-044 Hold req_valid = 1 with 4 requests while the FIFO is full -> no request is accepted while req_ready = 0; all 4 complete with none lost or duplicated.
REQ-045 Assert rst_n = 0 during RD_PULSE -> trigRead = 0 immediately; no resp_valid; busy = 0; next request after release behaves per REQ-032/REQ-033.
REQ-046 WR_CYCLES = 7, RD_CYCLES = 3 -> measured strobe widths are exactly 7 and 3 clocks.
